// File: rtl/bitcoin_job_host.sv
// Host side of the bitcoin hash core: loads a message into the shared word RAM,
// kicks the core, serves its memory port while it runs, then streams the results out.
module bitcoin_job_host #(
  parameter int          MEM_DEPTH      = 64,
  parameter logic [15:0] MSG_BASE       = 16'h0000,
  parameter int          MSG_WORDS      = 19,
  parameter logic [15:0] OUT_BASE       = 16'h0020,
  parameter int          NUM_RESULTS    = 16,
  parameter int          TIMEOUT_CYCLES = 8192
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        core_start,
  input  logic        core_done,
  output logic [15:0] core_message_addr,
  output logic [15:0] core_output_addr,
  input  logic        core_mem_we,
  input  logic [15:0] core_mem_addr,
  input  logic [31:0] core_mem_write_data,
  output logic [31:0] core_mem_read_data,
  output logic        busy,
  output logic        error,
  output logic [31:0] cycles
);

  localparam int          AW        = $clog2(MEM_DEPTH);
  localparam logic [15:0] MSG_LAST  = 16'(MSG_WORDS - 1);
  localparam logic [15:0] RES_LAST  = 16'(NUM_RESULTS - 1);
  localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_LOAD, S_START, S_RUN, S_DRAIN, S_ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] mem [MEM_DEPTH];
  logic [15:0] idx_q, j_q, j_next;
  logic [15:0] load_addr;
  logic [31:0] run_cnt_q, run_cnt_now;
  logic        load_fire, out_fire, drain_end, run_done, run_timeout;

  // Addresses beyond the RAM never alias: writes are dropped, reads return 0.
  function automatic logic addr_ok(input logic [15:0] a);
    return (a >> AW) == 16'd0;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    return addr_ok(a) ? mem[a[AW-1:0]] : 32'd0;
  endfunction

  assign core_message_addr = MSG_BASE;
  assign core_output_addr  = OUT_BASE;

  assign load_addr   = MSG_BASE + idx_q;
  assign load_fire   = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign j_next      = out_fire ? j_q + 16'd1 : j_q;
  assign drain_end   = (state_q == S_DRAIN) && out_fire && out_last;
  assign run_cnt_now = run_cnt_q + 32'd1;
  // A done seen in the first RUN cycle may be left over from the previous job.
  assign run_done    = (state_q == S_RUN) && core_done && (run_cnt_now != 32'd1);
  assign run_timeout = (state_q == S_RUN) && !run_done && (run_cnt_now == TIMEOUT_C);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_LOAD;
    else          state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    core_start = 1'b0;
    busy       = 1'b0;
    error      = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (load_fire && idx_q == MSG_LAST) state_d = S_START;
      end
      S_START: begin
        core_start = 1'b1;
        busy       = 1'b1;
        state_d    = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (run_done)         state_d = S_DRAIN;
        else if (run_timeout) state_d = S_ERR;
      end
      S_DRAIN: if (drain_end) state_d = S_LOAD;
      S_ERR:   error = 1'b1;
      default: state_d = S_LOAD;
    endcase
  end

  // NOTE: the RAM array is deliberately left out of reset; contents survive reset and jobs.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (load_fire && addr_ok(load_addr))
        mem[load_addr[AW-1:0]] <= in_data;
      else if (state_q == S_RUN && core_mem_we && addr_ok(core_mem_addr))
        mem[core_mem_addr[AW-1:0]] <= core_mem_write_data;
    end
  end

  // Drain re-reads the word that will be on the bus next cycle, so a stall
  // keeps re-fetching the same (unchanging) word and out_data stays stable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q              <= '0;
      j_q                <= '0;
      run_cnt_q          <= '0;
      cycles             <= '0;
      out_valid          <= 1'b0;
      out_last           <= 1'b0;
      out_data           <= '0;
      core_mem_read_data <= '0;
    end else begin
      case (state_q)
        S_LOAD:  if (load_fire) idx_q <= idx_q + 16'd1;
        S_START: run_cnt_q <= '0;
        S_RUN: begin
          run_cnt_q          <= run_cnt_now;
          core_mem_read_data <= mem_rd(core_mem_addr);
          if (run_done) begin
            cycles <= run_cnt_now;
            j_q    <= '0;
          end
        end
        S_DRAIN: begin
          if (drain_end) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            idx_q     <= '0;
          end else begin
            out_valid <= 1'b1;
            out_data  <= mem_rd(OUT_BASE + j_next);
            out_last  <= (j_next == RES_LAST);
            j_q       <= j_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
